// File: rtl/turn_pkg.sv
// Shared types and helpers for the N-player turn sequencer.
// Holds the state encoding and the seat-rotation function.
package turn_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        INFO  = 3'd1,
        HUMAN = 3'd2,
        CPU   = 3'd3,
        CHECK = 3'd4,
        OVER  = 3'd5
    } state_t;

    // Seat following idx in an n-seat rotation; wraps from n-1 back to 0.
    function automatic int next_player(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn seconds timer: a clk prescaler feeding a down-counting seconds register.
// expire flags the wrap cycle that takes the last second away.
module turn_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TURN_SECS     = 15,
    localparam int SW  = $clog2(TURN_SECS + 1),
    localparam int PSW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          run,
    output logic [SW-1:0] secs_left,
    output logic          expire
);

    logic [PSW-1:0] prescaler;
    logic           wrap;

    assign wrap   = run && (prescaler == PSW'(TICKS_PER_SEC - 1));
    assign expire = wrap && (secs_left == SW'(1));

    // Load wins over run so a fresh turn always starts from a full budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            secs_left <= '0;
        end else if (load) begin
            prescaler <= '0;
            secs_left <= SW'(TURN_SECS);
        end else if (run) begin
            if (wrap) begin
                prescaler <= '0;
                secs_left <= secs_left - SW'(1);
            end else begin
                prescaler <= prescaler + PSW'(1);
            end
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// N-player turn controller: rotates seats, times each turn and runs the
// victory/draw check after every committed move.
module turn_sequencer
    import turn_pkg::*;
#(
    parameter int                     NUM_PLAYERS   = 2,
    parameter logic [NUM_PLAYERS-1:0] CPU_MASK      = 2'b10,
    parameter int                     TICKS_PER_SEC = 50_000_000,
    parameter int                     TURN_SECS     = 15,
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int SW = $clog2(TURN_SECS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          move_valid,
    input  logic          cpu_done,
    input  logic          win,
    input  logic          draw,
    output logic [PW-1:0] cur_player,
    output logic          info,
    output logic          alu_en,
    output logic          pmw,
    output logic [SW-1:0] secs_left,
    output logic          timeout,
    output logic          game_over,
    output logic          winner_valid,
    output logic [PW-1:0] winner
);

    // Mask padded to the full index range so any cur_player value selects in bounds.
    localparam int            MW       = 1 << PW;
    localparam logic [MW-1:0] CPU_PAD  = MW'(CPU_MASK);

    state_t state;
    logic   expire;

    assign info      = (state == INFO);
    assign alu_en    = (state == HUMAN);
    assign pmw       = (state == CPU);
    assign game_over = (state == OVER);

    turn_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .TURN_SECS     (TURN_SECS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (state == INFO),
        .run       ((state == HUMAN) || (state == CPU)),
        .secs_left (secs_left),
        .expire    (expire)
    );

    // A committed move always beats a same-cycle expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cur_player   <= '0;
            timeout      <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= INFO;
                        cur_player <= '0;
                    end
                end
                INFO: begin
                    state <= CPU_PAD[cur_player] ? CPU : HUMAN;
                end
                HUMAN: begin
                    if (move_valid) begin
                        state <= CHECK;
                    end else if (expire) begin
                        state      <= INFO;
                        cur_player <= PW'(next_player(int'(cur_player), NUM_PLAYERS));
                        timeout    <= 1'b1;
                    end
                end
                CPU: begin
                    if (cpu_done) begin
                        state <= CHECK;
                    end else if (expire) begin
                        state      <= INFO;
                        cur_player <= PW'(next_player(int'(cur_player), NUM_PLAYERS));
                        timeout    <= 1'b1;
                    end
                end
                CHECK: begin
                    if (win) begin
                        state        <= OVER;
                        winner       <= cur_player;
                        winner_valid <= 1'b1;
                    end else if (draw) begin
                        state        <= OVER;
                        winner_valid <= 1'b0;
                    end else begin
                        state      <= INFO;
                        cur_player <= PW'(next_player(int'(cur_player), NUM_PLAYERS));
                    end
                end
                OVER: begin
                    if (start) begin
                        state        <= INFO;
                        cur_player   <= '0;
                        winner_valid <= 1'b0;
                        winner       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: 3 seats, seat 1 CPU, 4 ticks/s, 3 s turns.
// Expected turn-start and game-over events are queued by stimulus and popped by a monitor.
module tb_turn_sequencer;

    localparam int NP = 3;
    localparam int PW = 2;
    localparam int SW = 2;

    typedef struct {
        bit       is_over;
        int       player;
        bit       tmo;
        bit       wv;
        int       wnr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          move_valid = 1'b0;
    logic          cpu_done = 1'b0;
    logic          win = 1'b0;
    logic          draw = 1'b0;
    logic [PW-1:0] cur_player;
    logic          info;
    logic          alu_en;
    logic          pmw;
    logic [SW-1:0] secs_left;
    logic          timeout;
    logic          game_over;
    logic          winner_valid;
    logic [PW-1:0] winner;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_over = 1'b0;

    turn_sequencer #(
        .NUM_PLAYERS   (NP),
        .CPU_MASK      (3'b010),
        .TICKS_PER_SEC (4),
        .TURN_SECS     (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .move_valid   (move_valid),
        .cpu_done     (cpu_done),
        .win          (win),
        .draw         (draw),
        .cur_player   (cur_player),
        .info         (info),
        .alu_en       (alu_en),
        .pmw          (pmw),
        .secs_left    (secs_left),
        .timeout      (timeout),
        .game_over    (game_over),
        .winner_valid (winner_valid),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock; inputs change and direct checks happen 1 time unit after the edge.
    task automatic applyStimulus(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectTurn(input int player, input bit tmo);
        exp_t e;
        e.is_over = 1'b0; e.player = player; e.tmo = tmo; e.wv = 1'b0; e.wnr = 0;
        sb.push_back(e);
    endtask

    task automatic expectOver(input bit wv, input int wnr);
        exp_t e;
        e.is_over = 1'b1; e.player = 0; e.tmo = 1'b0; e.wv = wv; e.wnr = wnr;
        sb.push_back(e);
    endtask

    // Monitor: turn starts (info) and game-over entries are matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (info || (game_over && !prev_over))) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event: got info=%0b game_over=%0b, expected none", info, game_over);
            end else begin
                e = sb.pop_front();
                if (e.is_over != game_over || (info && (cur_player != e.player || timeout != e.tmo))
                    || (game_over && (winner_valid != e.wv || (e.wv && winner != e.wnr)))) begin
                    errors++;
                    $display("[TB] FAIL event: got over=%0b player=%0d timeout=%0b wv=%0b winner=%0d, expected over=%0b player=%0d timeout=%0b wv=%0b winner=%0d",
                             game_over, cur_player, timeout, winner_valid, winner,
                             e.is_over, e.player, e.tmo, e.wv, e.wnr);
                end
            end
        end
        prev_over <= game_over;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of stimulus, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(2);
        checkOutput("rst_cur_player", cur_player, 0);
        checkOutput("rst_strobes", {info, alu_en, pmw, timeout}, 0);
        checkOutput("rst_over_fields", {game_over, winner_valid, winner}, 0);
        checkOutput("rst_secs_left", secs_left, 0);
        rst = 1'b0;
        applyStimulus();

        // Start game: one INFO cycle for seat 0, then a human turn.
        start = 1'b1;
        expectTurn(0, 1'b0);
        applyStimulus();
        start = 1'b0;
        checkOutput("start_info", info, 1);
        applyStimulus();
        checkOutput("human_alu_en", alu_en, 1);
        checkOutput("human_secs_3", secs_left, 3);

        // Idle human turn runs out after 12 cycles.
        applyStimulus(3);
        checkOutput("secs_cycle4", secs_left, 3);
        applyStimulus();
        checkOutput("secs_cycle5", secs_left, 2);
        applyStimulus(4);
        checkOutput("secs_cycle9", secs_left, 1);
        applyStimulus(3);
        checkOutput("secs_cycle12", secs_left, 1);
        checkOutput("no_timeout_before_expiry", timeout, 0);
        expectTurn(1, 1'b1);
        applyStimulus();
        checkOutput("expiry_secs_0", secs_left, 0);
        checkOutput("expiry_timeout", timeout, 1);
        applyStimulus();
        checkOutput("cpu_pmw", pmw, 1);
        checkOutput("timeout_one_cycle", timeout, 0);
        checkOutput("cpu_secs_3", secs_left, 3);

        // move_valid is ignored while a CPU seat is playing.
        move_valid = 1'b1;
        applyStimulus();
        move_valid = 1'b0;
        checkOutput("cpu_ignores_move", pmw, 1);
        cpu_done = 1'b1;
        expectTurn(2, 1'b0);
        applyStimulus();
        cpu_done = 1'b0;
        checkOutput("check_strobes", {info, alu_en, pmw}, 0);
        applyStimulus(2);
        checkOutput("seat2_human", alu_en, 1);

        // cpu_done and start are ignored during a human turn.
        cpu_done = 1'b1;
        start    = 1'b1;
        applyStimulus();
        cpu_done = 1'b0;
        start    = 1'b0;
        checkOutput("human_ignores_cpu_done", alu_en, 1);
        checkOutput("start_ignored_player", cur_player, 2);

        // Seat 2 moves, wrap back to seat 0, then seats 0 and 1 move.
        move_valid = 1'b1;
        expectTurn(0, 1'b0);
        applyStimulus();
        move_valid = 1'b0;
        applyStimulus(2);
        move_valid = 1'b1;
        expectTurn(1, 1'b0);
        applyStimulus();
        move_valid = 1'b0;
        applyStimulus(2);
        checkOutput("seat1_cpu", pmw, 1);
        cpu_done = 1'b1;
        expectTurn(2, 1'b0);
        applyStimulus();
        cpu_done = 1'b0;
        applyStimulus(2);

        // Seat 2 wins with draw also raised: win takes priority.
        move_valid = 1'b1;
        win = 1'b1;
        draw = 1'b1;
        applyStimulus();
        move_valid = 1'b0;
        expectOver(1'b1, 2);
        applyStimulus();
        win = 1'b0;
        draw = 1'b0;
        checkOutput("win_game_over", game_over, 1);
        checkOutput("win_winner", winner, 2);
        checkOutput("win_valid", winner_valid, 1);
        applyStimulus(2);
        checkOutput("over_holds_winner", {game_over, winner_valid, winner}, {1'b1, 1'b1, 2'd2});

        // Restart from OVER clears winner fields.
        start = 1'b1;
        expectTurn(0, 1'b0);
        applyStimulus();
        start = 1'b0;
        checkOutput("restart_player", cur_player, 0);
        checkOutput("restart_winner_fields", {winner_valid, winner}, 0);
        applyStimulus();

        // Pure draw.
        move_valid = 1'b1;
        applyStimulus();
        move_valid = 1'b0;
        draw = 1'b1;
        expectOver(1'b0, 0);
        applyStimulus();
        draw = 1'b0;
        checkOutput("draw_over", {game_over, winner_valid}, {1'b1, 1'b0});
        start = 1'b1;
        expectTurn(0, 1'b0);
        applyStimulus();
        start = 1'b0;
        applyStimulus();

        // Move in the expiry cycle beats the timeout.
        applyStimulus(11);
        checkOutput("exp_cycle_secs", secs_left, 1);
        move_valid = 1'b1;
        applyStimulus();
        move_valid = 1'b0;
        checkOutput("move_beats_expiry_timeout", timeout, 0);
        checkOutput("move_beats_expiry_state", {info, alu_en}, 0);
        expectTurn(1, 1'b0);
        applyStimulus();
        checkOutput("after_move_timeout", timeout, 0);
        applyStimulus();

        // Reset mid-CPU turn with two seconds left.
        applyStimulus(4);
        checkOutput("mid_cpu_secs_2", secs_left, 2);
        checkOutput("mid_cpu_pmw", pmw, 1);
        rst = 1'b1;
        #2;
        checkOutput("async_rst_outputs",
                    {cur_player, info, alu_en, pmw, secs_left, timeout, game_over, winner_valid, winner}, 0);
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checkOutput("idle_after_rst", {info, alu_en, pmw}, 0);
        start = 1'b1;
        expectTurn(0, 1'b0);
        applyStimulus();
        start = 1'b0;
        applyStimulus();
        checkOutput("post_rst_human", alu_en, 1);
        checkOutput("post_rst_secs", secs_left, 3);

        applyStimulus(2);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Parametrised N-player turn controller for the board-game datapath; successor to the fixed 2-player, 4-state game FSM.
- Sequences turns over NUM_PLAYERS seats, any of which can be CPU-driven (CPU_MASK).
- Enforces a per-turn time limit with an internal seconds timer and runs a victory/draw check after every move.
- Raises the same turn-phase strobes as before: info (turn start), alu_en (human turn), pmw (CPU turn).

Parameters:
- NUM_PLAYERS, 2: number of seats, 2..8.
- CPU_MASK, 2'b10: bit i set means seat i is CPU-controlled; width NUM_PLAYERS.
- TICKS_PER_SEC, 50_000_000: clk cycles per second.
- TURN_SECS, 15: seconds allowed per turn, at least 1.
- PW, $clog2(NUM_PLAYERS) (localparam, min 1): player index width.
- SW, $clog2(TURN_SECS+1) (localparam): seconds counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a game; accepted in IDLE or OVER.
- move_valid  in  1  human seat committed a move; sampled in HUMAN only.
- cpu_done  in  1  CPU engine committed a move; sampled in CPU only.
- win  in  1  victory-check result for cur_player; sampled in CHECK only.
- draw  in  1  board-full or no-move result; sampled in CHECK only.
- cur_player  out  PW  seat whose turn it is.
- info  out  1  high in INFO (turn start, timer load).
- alu_en  out  1  high in HUMAN.
- pmw  out  1  high in CPU.
- secs_left  out  SW  remaining seconds of the current turn.
- timeout  out  1  one-cycle pulse when a turn expires.
- game_over  out  1  high in OVER.
- winner_valid  out  1  in OVER: 1 means win, 0 means draw.
- winner  out  PW  winning seat; meaningful only when winner_valid is 1.

Behaviour:
- Reset (rst asynchronous, active-high, dominant at any time including mid-turn):
  - state = IDLE, cur_player = 0, secs_left = 0, prescaler = 0.
  - All strobes, timeout, game_over, winner_valid and winner = 0.
- All outputs are registered or decoded directly from the state register. No combinational path from inputs to outputs.
- States: IDLE, INFO, HUMAN, CPU, CHECK, OVER.
  - IDLE: start -> INFO with cur_player = 0.
  - INFO: lasts exactly 1 cycle. Loads secs_left = TURN_SECS and prescaler = 0. Next state is CPU if CPU_MASK[cur_player], else HUMAN.
  - HUMAN: move_valid -> CHECK. Otherwise, on expiry -> INFO with cur_player advanced and timeout pulsed.
  - CPU: cpu_done -> CHECK. Expiry is handled as in HUMAN (CPU stall guard).
  - CHECK: lasts exactly 1 cycle.
    - win -> OVER, winner = cur_player, winner_valid = 1.
    - else draw -> OVER, winner_valid = 0.
    - else -> INFO with cur_player advanced.
  - OVER: holds winner fields. start -> INFO with cur_player = 0 and winner fields cleared.
- Player advance: cur_player + 1, wrapping from NUM_PLAYERS-1 to 0. Index values >= NUM_PLAYERS never appear.
- Timer (runs only in HUMAN and CPU; frozen elsewhere):
  - prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - On wrap, secs_left decrements.
  - Expiry = wrap cycle with secs_left == 1. secs_left becomes 0 and timeout is high for the following cycle, which coincides with INFO.
  - Turn length is exactly TURN_SECS*TICKS_PER_SEC cycles in HUMAN or CPU.
- Simultaneous events:
  - move_valid or cpu_done in the expiry cycle: the move wins; no timeout, go to CHECK.
  - win and draw together: win wins.
  - start outside IDLE/OVER: ignored.
  - move_valid in CPU state, or cpu_done in HUMAN state: ignored.

Decomposition:
- Package turn_pkg:
  - typedef enum logic [2:0] state_t {IDLE, INFO, HUMAN, CPU, CHECK, OVER}.
  - Encoding constants.
  - Helper function next_player(idx, n).
- Sub-module turn_timer (params TICKS_PER_SEC, TURN_SECS):
  - Ports: clk, rst, load, run, secs_left, expire.
  - Holds prescaler and seconds counter. expire is combinational on the wrap cycle with secs_left == 1.

Test Plan (TICKS_PER_SEC=4, TURN_SECS=3, NUM_PLAYERS=3, CPU_MASK=3'b010 unless noted):
- Reset then start -> INFO for 1 cycle with cur_player=0, then HUMAN, alu_en=1, secs_left=3.
- HUMAN with no input for 12 cycles -> secs_left steps 3,2,1,0 every 4 cycles; timeout=1 for 1 cycle; INFO with cur_player=1; then CPU with pmw=1.
- Seat 0 move_valid (win=0, draw=0), then cpu_done, then seat 2 move_valid -> cur_player cycles 0,1,2 and wraps to 0 after the third CHECK.
- Seat 2 move with win=1 and draw=1 in CHECK -> game_over=1, winner_valid=1, winner=2; start -> INFO, cur_player=0, winner_valid=0.
- move_valid asserted in the 12th HUMAN cycle (the expiry cycle) -> CHECK, timeout stays 0.
- rst pulsed mid-CPU turn with secs_left=2 -> all outputs 0 immediately, state IDLE; later start restarts cleanly at seat 0.
